// File: rtl/systolic_ctrl.sv
// Systolic array sequencer: operand fetch, skewed row/column enables, drain timing, result handshake.
// Optional perf counters are built when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_ctrl #(
   parameter int N        = 4,
   parameter int KW       = 8,
   parameter int RD_LAT   = 1,
   parameter int MULT_LAT = 1
) (
   input  logic          i_clk,
   input  logic          i_arst_n,
   input  logic          i_start,
   output logic          o_start_ready,
   input  logic [KW-1:0] i_k,
   input  logic          i_abort,
   output logic          o_rd_en,
   output logic [KW-1:0] o_rd_addr,
   output logic [N-1:0]  o_row_en,
   output logic [N-1:0]  o_col_en,
   output logic          o_doProcess,
   output logic          o_res_valid,
   input  logic          i_res_ready,
   output logic          o_busy,
   output logic          o_done,
   output logic [31:0]   o_perf_cycles,
   output logic [15:0]   o_perf_jobs
);

   // state    | meaning
   // S_IDLE   | waiting for a job, PE accumulators held clear
   // S_FEED   | reading K operand slices from the buffer
   // S_DRAIN  | waiting for the skewed wavefront to reach the last PE
   // S_RESULT | array outputs valid until consumed
   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_RESULT} state_t;

   localparam int D  = RD_LAT + 2*(N-1) + MULT_LAT + 1;
   localparam int DW = $clog2(D+1);
   localparam int SL = RD_LAT + N - 1;

   state_t          r_state;
   logic [KW-1:0]   r_k;
   logic [KW-1:0]   r_addr;
   logic [DW-1:0]   r_drain;
   logic [SL-1:0]   r_sh;

   logic w_accept;
   logic w_rd_en;
   logic w_done;
   logic w_abort;

   assign w_accept = i_start && (r_state == S_IDLE);
   assign w_rd_en  = (r_state == S_FEED);
   assign w_abort  = i_abort && (r_state != S_IDLE);
   assign w_done   = (r_state == S_RESULT) && i_res_ready && !i_abort;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_addr  <= '0;
         r_drain <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_k     <= i_k;
                  r_addr  <= '0;
                  r_state <= (i_k == '0) ? S_RESULT : S_FEED;
               end
            end
            S_FEED: begin
               if (i_abort) begin
                  r_addr  <= '0;
                  r_state <= S_IDLE;
               end else if (r_addr == r_k - KW'(1)) begin
                  r_addr  <= '0;
                  r_drain <= DW'(D - 1);
                  r_state <= S_DRAIN;
               end else begin
                  r_addr <= r_addr + KW'(1);
               end
            end
            S_DRAIN: begin
               if (i_abort) begin
                  r_state <= S_IDLE;
               end else if (r_drain == '0) begin
                  r_state <= S_RESULT;
               end else begin
                  r_drain <= r_drain - DW'(1);
               end
            end
            S_RESULT: begin
               if (i_abort || i_res_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // r_sh[j] is o_rd_en delayed by j+1 cycles
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_sh <= '0;
      end else if (r_state == S_IDLE || w_abort) begin
         r_sh <= '0;
      end else begin
         r_sh[0] <= w_rd_en;
         for (int j = 1; j < SL; j++) begin
            r_sh[j] <= r_sh[j-1];
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_skew
      if (RD_LAT + i == 0) begin : g_nodly
         assign o_row_en[i] = w_rd_en;
      end else begin : g_dly
         assign o_row_en[i] = r_sh[RD_LAT+i-1];
      end
   end
   assign o_col_en = o_row_en;

   assign o_start_ready = (r_state == S_IDLE);
   assign o_rd_en       = w_rd_en;
   assign o_rd_addr     = r_addr;
   assign o_busy        = (r_state != S_IDLE);
   assign o_doProcess   = (r_state != S_IDLE);
   assign o_res_valid   = (r_state == S_RESULT);
   assign o_done        = w_done;

`ifdef SYSTOLIC_CTRL_PERF_EN
   logic [31:0] r_perf_cycles;
   logic [15:0] r_perf_jobs;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_perf_cycles <= '0;
         r_perf_jobs   <= '0;
      end else begin
         if (r_state != S_IDLE && r_perf_cycles != '1) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
         end
         if (w_done) begin
            r_perf_jobs <= r_perf_jobs + 16'd1;
         end
      end
   end

   assign o_perf_cycles = r_perf_cycles;
   assign o_perf_jobs   = r_perf_jobs;
`else
   assign o_perf_cycles = '0;
   assign o_perf_jobs   = '0;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl at N=4, KW=8, RD_LAT=1, MULT_LAT=1 (drain length 9).
module tb_systolic_ctrl;
   logic        clk;
   logic        arst_n;
   logic        start;
   logic        start_ready;
   logic [7:0]  k;
   logic        abort;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [3:0]  row_en;
   logic [3:0]  col_en;
   logic        do_process;
   logic        res_valid;
   logic        res_ready;
   logic        busy;
   logic        done;
   logic [31:0] perf_cycles;
   logic [15:0] perf_jobs;

   int vectors;
   int miscompares;
   int exp_jobs;

   systolic_ctrl #(.N(4), .KW(8), .RD_LAT(1), .MULT_LAT(1)) dut (
      .i_clk         (clk),
      .i_arst_n      (arst_n),
      .i_start       (start),
      .o_start_ready (start_ready),
      .i_k           (k),
      .i_abort       (abort),
      .o_rd_en       (rd_en),
      .o_rd_addr     (rd_addr),
      .o_row_en      (row_en),
      .o_col_en      (col_en),
      .o_doProcess   (do_process),
      .o_res_valid   (res_valid),
      .i_res_ready   (res_ready),
      .o_busy        (busy),
      .o_done        (done),
      .o_perf_cycles (perf_cycles),
      .o_perf_jobs   (perf_jobs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      exp_jobs    = 0;
      arst_n      = 1'b0;
      start       = 1'b0;
      k           = 8'd0;
      abort       = 1'b0;
      res_ready   = 1'b0;
      #12;
      check("rst_busy",      {31'd0, busy},        32'd0);
      check("rst_rd_en",     {31'd0, rd_en},       32'd0);
      check("rst_row_en",    {28'd0, row_en},      32'd0);
      check("rst_res_valid", {31'd0, res_valid},   32'd0);
      check("rst_perf_cyc",  perf_cycles,          32'd0);
      arst_n = 1'b1;
      step();
      check("rst_ready", {31'd0, start_ready}, 32'd1);

      // Job 1: K=3, result consumed immediately
      start = 1'b1; k = 8'd3; res_ready = 1'b1;
      #1;
      for (int c = 1; c <= 14; c++) begin
         step();
         start = 1'b0;
         #1;
         check($sformatf("j1_rd_en_c%0d", c),   {31'd0, rd_en},      {31'd0, (c >= 1 && c <= 3)});
         check($sformatf("j1_addr_c%0d", c),    {24'd0, rd_addr},    (c >= 1 && c <= 3) ? c - 1 : 0);
         check($sformatf("j1_row0_c%0d", c),    {31'd0, row_en[0]},  {31'd0, (c >= 2 && c <= 4)});
         check($sformatf("j1_row3_c%0d", c),    {31'd0, row_en[3]},  {31'd0, (c >= 5 && c <= 7)});
         check($sformatf("j1_col3_c%0d", c),    {31'd0, col_en[3]},  {31'd0, (c >= 5 && c <= 7)});
         check($sformatf("j1_valid_c%0d", c),   {31'd0, res_valid},  {31'd0, (c == 13)});
         check($sformatf("j1_done_c%0d", c),    {31'd0, done},       {31'd0, (c == 13)});
         check($sformatf("j1_busy_c%0d", c),    {31'd0, busy},       {31'd0, (c <= 13)});
         check($sformatf("j1_dop_c%0d", c),     {31'd0, do_process}, {31'd0, (c <= 13)});
      end
      exp_jobs++;

      // Job 2: identical, back to back
      start = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         step();
         start = 1'b0;
      end
      exp_jobs++;
      #1;
      check("j2_idle", {31'd0, start_ready}, 32'd1);
`ifdef SYSTOLIC_CTRL_PERF_EN
      check("perf_jobs_2", {16'd0, perf_jobs}, 32'd2);
      check("perf_cyc_2",  perf_cycles,        32'd26);
`else
      check("perf_jobs_2", {16'd0, perf_jobs}, 32'd0);
      check("perf_cyc_2",  perf_cycles,        32'd0);
`endif

      // K=0 with abort in IDLE: accepted, straight to RESULT
      start = 1'b1; k = 8'd0; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      #1;
      check("k0_valid_c1", {31'd0, res_valid}, 32'd1);
      check("k0_rd_en_c1", {31'd0, rd_en},     32'd0);
      check("k0_done_c1",  {31'd0, done},      32'd1);
      step();
      check("k0_idle_c2",  {31'd0, busy},      32'd0);
      check("k0_rd_en_c2", {31'd0, rd_en},     32'd0);
      exp_jobs++;

      // Abort in cycle 6 of a K=3 job
      start = 1'b1; k = 8'd3;
      for (int c = 1; c <= 6; c++) begin
         step();
         start = 1'b0;
      end
      abort = 1'b1;
      #1;
      check("ab_row3_c6", {31'd0, row_en[3]}, 32'd1);
      check("ab_done_c6", {31'd0, done},      32'd0);
      step();
      abort = 1'b0;
      check("ab_busy_c7",  {31'd0, busy},       32'd0);
      check("ab_row_c7",   {28'd0, row_en},     32'd0);
      check("ab_dop_c7",   {31'd0, do_process}, 32'd0);
      check("ab_ready_c7", {31'd0, start_ready}, 32'd1);
      step();
      check("ab_dop_c8",   {31'd0, do_process}, 32'd0);
      check("ab_done_c8",  {31'd0, done},       32'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
      check("ab_jobs", {16'd0, perf_jobs}, exp_jobs);
`else
      check("ab_jobs", {16'd0, perf_jobs}, 32'd0);
`endif

      // Result held with ready low for 5 cycles, start ignored throughout
      start = 1'b1; k = 8'd3; res_ready = 1'b0;
      step();
      start = 1'b0;
      for (int c = 2; c <= 13; c++) step();
      start = 1'b1; k = 8'd0;
      for (int c = 13; c <= 17; c++) begin
         #1;
         check($sformatf("hold_valid_c%0d", c), {31'd0, res_valid},   32'd1);
         check($sformatf("hold_ready_c%0d", c), {31'd0, start_ready}, 32'd0);
         check($sformatf("hold_done_c%0d", c),  {31'd0, done},        32'd0);
         check($sformatf("hold_rd_c%0d", c),    {31'd0, rd_en},       32'd0);
         step();
      end
      start = 1'b0; res_ready = 1'b1;
      #1;
      check("hold_valid_c18", {31'd0, res_valid}, 32'd1);
      check("hold_done_c18",  {31'd0, done},      32'd1);
      step();
      check("hold_idle_c19",  {31'd0, busy},      32'd0);
      exp_jobs++;
`ifdef SYSTOLIC_CTRL_PERF_EN
      check("hold_jobs", {16'd0, perf_jobs}, exp_jobs);
`else
      check("hold_jobs", {16'd0, perf_jobs}, 32'd0);
`endif

      // Reset mid-FEED
      start = 1'b1; k = 8'd3;
      step();
      start = 1'b0;
      step();
      check("mr_rd_before", {31'd0, rd_en}, 32'd1);
      arst_n = 1'b0;
      #1;
      check("mr_rd_en",   {31'd0, rd_en},      32'd0);
      check("mr_addr",    {24'd0, rd_addr},    32'd0);
      check("mr_row",     {28'd0, row_en},     32'd0);
      check("mr_busy",    {31'd0, busy},       32'd0);
      check("mr_dop",     {31'd0, do_process}, 32'd0);
      check("mr_done",    {31'd0, done},       32'd0);
      check("mr_pjobs",   {16'd0, perf_jobs},  32'd0);
      check("mr_pcyc",    perf_cycles,         32'd0);
      #2;
      arst_n = 1'b1;
      step();
      check("mr_ready", {31'd0, start_ready}, 32'd1);
      check("mr_busy2", {31'd0, busy},        32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, giving the PE array dimension (N x N); legal range 2..16.
REQ-002 SHALL have parameter KW, default 8, giving the width of the inner dimension K and of the read address.
REQ-003 SHALL have parameter RD_LAT, default 1, giving the operand buffer read latency in cycles.
REQ-004 SHALL have parameter MULT_LAT, default 1, giving the PE multiplier latency in cycles.
REQ-005 SHALL have ports, in this order:
- i_clk  in  1  clock; single clock domain.
- i_arst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  job request.
- o_start_ready  out  1  job can be accepted.
- i_k  in  KW  inner dimension K, sampled on accept.
- i_abort  in  1  cancel the current job.
- o_rd_en  out  1  operand buffer read strobe.
- o_rd_addr  out  KW  operand buffer read address (k index).
- o_row_en  out  N  per-row operand-valid (skewed); external mux drives 0 when low.
- o_col_en  out  N  per-column operand-valid (skewed); external mux drives 0 when low.
- o_doProcess  out  1  broadcast to every PE i_doProcess.
- o_res_valid  out  1  array o_y outputs hold the final result.
- i_res_ready  in  1  result consumed.
- o_busy  out  1  controller not IDLE.
- o_done  out  1  one-cycle pulse on result accept.
- o_perf_cycles  out  32  busy-cycle counter.
- o_perf_jobs  out  16  completed-job counter.

Function
REQ-006 SHALL implement the states IDLE, FEED, DRAIN and RESULT.
REQ-007 SHALL accept a job when i_start and o_start_ready are both 1 on the same edge; o_start_ready SHALL be 1 only in IDLE.
REQ-008 On accept, SHALL latch i_k; if K>0 go to FEED, if K=0 go directly to RESULT (all results zero).
REQ-009 In FEED, o_rd_en SHALL be 1 for exactly K cycles; o_rd_addr SHALL be 0 on the first cycle, +1 per cycle, reaching K-1 on the last.
REQ-010 SHALL compute o_row_en[i] and o_col_en[i] as o_rd_en delayed by RD_LAT+i cycles, using a shift register cleared in IDLE and on abort.
REQ-011 SHALL hold DRAIN for exactly D = RD_LAT + 2(N-1) + MULT_LAT + 1 cycles, counted by a down-counter, then go to RESULT.
REQ-012 o_doProcess SHALL be 1 in FEED, DRAIN and RESULT and 0 in IDLE, so PE accumulators are cleared whenever the controller is idle.
REQ-013 In RESULT, o_res_valid SHALL be 1 and held until i_res_ready=1. On that edge: pulse o_done for one cycle and go to IDLE.
REQ-014 Timing, with accept at cycle 0: o_rd_en high in cycles 1..K; DRAIN in cycles K+1..K+D; o_res_valid first high in cycle K+D+1.
REQ-015 i_abort=1 in FEED, DRAIN or RESULT SHALL force IDLE on the next edge, with no o_done and no job count. Abort together with i_res_ready in RESULT: abort wins.
REQ-016 i_abort in IDLE SHALL have no effect; i_start together with i_abort in IDLE SHALL be accepted.
REQ-017 o_busy SHALL be 1 exactly when the state is not IDLE; i_start outside IDLE SHALL be ignored.
REQ-018 Address and K arithmetic SHALL be unsigned KW bits; maximum K = 2^KW-1 with no address wrap inside a job.

Reset
REQ-019 On i_arst_n=0 the block SHALL asynchronously enter IDLE and hold all of the following at 0:
- o_rd_en, o_rd_addr, o_row_en, o_col_en
- o_doProcess, o_res_valid, o_done, o_busy
- the perf counters
REQ-020 After i_arst_n deasserts, o_start_ready SHALL be 1; a reset mid-job SHALL discard the job.

Configuration
REQ-021 With macro SYSTOLIC_CTRL_PERF_EN defined, o_perf_cycles SHALL count busy cycles, saturating at 2^32-1, and o_perf_jobs SHALL count o_done pulses, wrapping.
REQ-022 Without SYSTOLIC_CTRL_PERF_EN, both perf ports SHALL remain present and be tied to 0, with no counter logic.

Verification
REQ-023 N=4, RD_LAT=1, MULT_LAT=1, K=3, i_res_ready=1:
- o_rd_en high in cycles 1..3 with addresses 0,1,2.
- o_row_en[3] high in cycles 5..7.
- o_res_valid in cycle 13; o_done pulses in cycle 13.
REQ-024 K=0 accepted at cycle 0 -> o_rd_en never high; o_res_valid in cycle 1.
REQ-025 i_abort in cycle 6 of a K=3 job:
- IDLE at cycle 7 and o_row_en=0.
- o_doProcess=0 from cycle 7.
- no o_done; o_perf_jobs unchanged.
REQ-026 i_res_ready held 0 for 5 cycles in RESULT -> o_res_valid stays 1 and the state holds; i_start is ignored throughout.
REQ-027 i_arst_n pulsed low mid-FEED -> all outputs 0 immediately; o_start_ready=1 after release.
REQ-028 With SYSTOLIC_CTRL_PERF_EN, two K=3 jobs with immediate ready -> o_perf_jobs=2 and o_perf_cycles=26; without the macro both read 0.
